// File: rtl/pitch_ol_energy.sv
// Open-loop pitch energy: out = 1 + sum(L_mult(x,x)) over strided scratch samples, saturating (G.729 L_mac).
// Latency: done rises N+2 cycles after start is accepted; start ignored while busy.
module pitch_ol_energy #(
    parameter int FRAME_LEN = 80,
    parameter int STEP      = 2,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    output logic [ADDR_W-1:0] scratchMemAddr,
    input  logic [31:0]       scratchMemIn,
    output logic              done,
    output logic [31:0]       out
);
    localparam int NTERMS = (FRAME_LEN + STEP - 1) / STEP;
    localparam int CNT_W  = $clog2(NTERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NTERMS);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   termCnt;
    logic [ADDR_W-1:0]  nextAddr;
    logic               rdVld;
    logic [31:0]        acc;
    logic               accept;

    logic signed [15:0] sample;
    logic signed [31:0] square;
    logic [31:0]        term;
    logic [32:0]        sum;
    logic [31:0]        accSum;
    logic               unusedBits;

    assign accept = start && (state == IDLE || state == DONE);

    // L_mult(x,x) then L_add; both operands are non-negative so only positive saturation exists.
    assign sample     = scratchMemIn[15:0];
    assign square     = 32'(sample) * 32'(sample);
    assign term       = (sample == -16'sd32768) ? 32'h7FFF_FFFF : {square[30:0], 1'b0};
    assign sum        = {1'b0, acc} + {1'b0, term};
    assign accSum     = (sum[32] || sum[31]) ? 32'h7FFF_FFFF : sum[31:0];
    assign unusedBits = &{1'b0, scratchMemIn[31:16], square[31]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: if (start) stateNext = READ;
            READ:       if (termCnt == LAST) stateNext = DRAIN;
            DRAIN:      stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratchMemAddr <= '0;
            nextAddr       <= '0;
            termCnt        <= '0;
            rdVld          <= 1'b0;
            acc            <= '0;
            done           <= 1'b0;
            out            <= '0;
        end else if (accept) begin
            nextAddr <= baseAddr;
            termCnt  <= '0;
            rdVld    <= 1'b0;
            acc      <= 32'h0000_0001;
            done     <= 1'b0;
        end else begin
            rdVld <= 1'b0;
            if (state == READ && termCnt != LAST) begin
                scratchMemAddr <= nextAddr;
                nextAddr       <= nextAddr + ADDR_W'(STEP);
                termCnt        <= termCnt + 1'b1;
                rdVld          <= 1'b1;
            end
            // Read data is consumed on the edge after its address was presented.
            if (rdVld) begin
                acc <= accSum;
            end
            if (state == DRAIN) begin
                done <= 1'b1;
                out  <= acc;
            end
        end
    end
endmodule

// File: tb/tb_pitch_ol_energy.sv
// Directed bench for pitch_ol_energy with a combinational scratch memory model.
module tb_pitch_ol_energy;
    localparam int N = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] baseAddr;
    logic [11:0] scratchMemAddr;
    logic [31:0] scratchMemIn;
    logic        done;
    logic [31:0] out;

    logic [15:0] mem [0:4095];
    logic [11:0] addrLog [0:63];
    logic [31:0] outMid;
    int          cyc;
    bit          tmo;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    // Upper half carries junk so only [15:0] may be used as the sample.
    assign scratchMemIn = {16'hA5A5, mem[scratchMemAddr]};

    pitch_ol_energy dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .baseAddr(baseAddr),
        .scratchMemAddr(scratchMemAddr),
        .scratchMemIn(scratchMemIn),
        .done(done),
        .out(out)
    );

    function automatic logic [31:0] model(input logic [11:0] b);
        longint a;
        logic [11:0] ad;
        shortint x;
        a = 1;
        for (int i = 0; i < N; i++) begin
            ad = b + 12'(2 * i);
            x  = shortint'(mem[ad]);
            if (x == -32768) a += 64'sd2147483647;
            else a += 2 * longint'(x) * longint'(x);
            if (a > 64'sd2147483647) a = 64'sd2147483647;
        end
        return a[31:0];
    endfunction

    task automatic fill(input logic [11:0] b, input logic [15:0] ev, input logic [15:0] od);
        logic [11:0] ad;
        for (int j = 0; j < 80; j++) begin
            ad = b + 12'(j);
            mem[ad] = (j % 2 == 1) ? od : ev;
        end
    endtask

    // Pulses start, then counts edges until done; optionally re-pulses start mid-run.
    task automatic run(input logic [11:0] b, input int restartAt);
        @(negedge clk);
        baseAddr = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        baseAddr = ~b;
        cyc = 0;
        tmo = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            if (c < 64) addrLog[c] = scratchMemAddr;
            if (c == 20) outMid = out;
            start = (c == restartAt);
            if (done) begin
                tmo = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (done !== 1'b0 || out !== 32'h0 || scratchMemAddr !== 12'h0) begin
            bad++;
            $display("FAIL reset: done=%b out=%h addr=%h want 0/0/0", done, out, scratchMemAddr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero;
        logic [11:0] ea;
        fill(12'h100, 16'h0, 16'h0);
        run(12'h100, 0);
        total++;
        if (tmo || cyc != 42) begin
            bad++;
            $display("FAIL zero_latency: cycles=%0d timeout=%b want 42", cyc, tmo);
        end
        total++;
        if (out !== 32'h0000_0001) begin
            bad++;
            $display("FAIL zero_out: out=%h want 00000001", out);
        end
        for (int c = 1; c <= N; c++) begin
            ea = 12'h100 + 12'(2 * (c - 1));
            total++;
            if (addrLog[c] !== ea) begin
                bad++;
                $display("FAIL zero_addr[%0d]: addr=%h want %h", c - 1, addrLog[c], ea);
            end
        end
        total++;
        if (scratchMemAddr !== 12'h14E) begin
            bad++;
            $display("FAIL addr_hold: addr=%h want 14e", scratchMemAddr);
        end
    endtask

    task automatic test_values100;
        fill(12'h100, 16'd100, 16'd100);
        run(12'h100, 0);
        total++;
        if (outMid !== 32'h0000_0001) begin
            bad++;
            $display("FAIL out_busy_hold: out=%h want 00000001", outMid);
        end
        total++;
        if (tmo || cyc != 42 || out !== 32'h000C_3501) begin
            bad++;
            $display("FAIL val100: out=%h cycles=%0d want 000c3501 at 42", out, cyc);
        end
        repeat (7) @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || out !== 32'h000C_3501) begin
            bad++;
            $display("FAIL done_hold: done=%b out=%h want 1/000c3501", done, out);
        end
    endtask

    task automatic test_saturation;
        fill(12'h100, 16'h8000, 16'h8000);
        run(12'h100, 0);
        total++;
        if (tmo || out !== 32'h7FFF_FFFF) begin
            bad++;
            $display("FAIL sat_min: out=%h want 7fffffff", out);
        end
        fill(12'h100, 16'h7FFF, 16'h7FFF);
        mem[12'h102] = 16'h0;
        mem[12'h104] = 16'h0;
        // Single big term first: only x[0]=32767, rest zero.
        for (int j = 2; j < 80; j++) mem[12'h100 + 12'(j)] = 16'h0;
        run(12'h100, 0);
        total++;
        if (tmo || out !== 32'h7FFE_0003) begin
            bad++;
            $display("FAIL max_term: out=%h want 7ffe0003", out);
        end
        fill(12'h100, 16'h7FFF, 16'h7FFF);
        run(12'h100, 0);
        total++;
        if (tmo || out !== 32'h7FFF_FFFF) begin
            bad++;
            $display("FAIL sat_max: out=%h want 7fffffff", out);
        end
    endtask

    task automatic test_stride;
        fill(12'h100, 16'd0, 16'd1000);
        run(12'h100, 0);
        total++;
        if (tmo || out !== 32'h0000_0001) begin
            bad++;
            $display("FAIL stride_odd: out=%h want 00000001", out);
        end
        mem[12'h100] = 16'hFFFD;
        run(12'h100, 0);
        total++;
        if (tmo || out !== 32'h0000_0013) begin
            bad++;
            $display("FAIL stride_neg3: out=%h want 00000013", out);
        end
    endtask

    task automatic test_wrap;
        logic [11:0] ad;
        logic [11:0] ea;
        logic [31:0] exp;
        for (int j = 0; j < 80; j++) begin
            ad = 12'hFF8 + 12'(j);
            mem[ad] = 16'(j * 37 - 1500);
        end
        exp = model(12'hFF8);
        run(12'hFF8, 0);
        for (int c = 1; c <= N; c++) begin
            ea = 12'hFF8 + 12'(2 * (c - 1));
            total++;
            if (addrLog[c] !== ea) begin
                bad++;
                $display("FAIL wrap_addr[%0d]: addr=%h want %h", c - 1, addrLog[c], ea);
            end
        end
        total++;
        if (tmo || cyc != 42 || out !== exp) begin
            bad++;
            $display("FAIL wrap_out: out=%h cycles=%0d want %h at 42", out, cyc, exp);
        end
    endtask

    task automatic test_reset_mid;
        bit early;
        fill(12'h200, 16'd100, 16'd100);
        @(negedge clk);
        baseAddr = 12'h200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (done !== 1'b0 || out !== 32'h0 || scratchMemAddr !== 12'h0) begin
            bad++;
            $display("FAIL reset_mid: done=%b out=%h addr=%h want 0/0/0", done, out, scratchMemAddr);
        end
        @(negedge clk);
        reset = 1'b0;
        early = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || scratchMemAddr !== 12'h0) early = 1'b1;
        end
        total++;
        if (early) begin
            bad++;
            $display("FAIL idle_after_reset: done=%b addr=%h want 0/0", done, scratchMemAddr);
        end
        run(12'h200, 0);
        total++;
        if (tmo || cyc != 42 || out !== 32'h000C_3501) begin
            bad++;
            $display("FAIL after_reset_run: out=%h cycles=%0d want 000c3501 at 42", out, cyc);
        end
    endtask

    task automatic test_restart_ignored;
        fill(12'h300, 16'd7, 16'd7);
        run(12'h300, 5);
        total++;
        if (tmo || cyc != 42 || out !== 32'h0000_0F51) begin
            bad++;
            $display("FAIL restart_ignored: out=%h cycles=%0d want 00000f51 at 42", out, cyc);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        baseAddr = 12'h0;
        outMid = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h7777;
        test_reset;
        test_zero;
        test_values100;
        test_saturation;
        test_stride;
        test_wrap;
        test_reset_mid;
        test_restart_ignored;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
